gshare_ras_predictor: RTL and testbench

GSHARE_RAS_PREDICTOR -- requirements
Module: gshare_ras_predictor

---
 rtl/bp_pkg.sv | 18 +
 rtl/bp_ras.sv | 65 ++++++
 rtl/gshare_ras_predictor.sv | 164 ++++++++++++++++
 tb/tb_gshare_ras_predictor.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and default sizing for the gshare + RAS branch predictor.
package bp_pkg;

  typedef enum logic [1:0] {
    COND = 2'd0,
    JUMP = 2'd1,
    CALL = 2'd2,
    RET  = 2'd3
  } br_type_t;

  localparam int XLEN_DEF      = 32;
  localparam int BTB_IDX_W_DEF = 5;
  localparam int PHT_IDX_W_DEF = 5;
  localparam int GHR_W_DEF     = 5;
  localparam int CNT_W_DEF     = 2;
  localparam int RAS_DEPTH_DEF = 4;

endpackage

// File: rtl/bp_ras.sv
// Circular return address stack: a push when full overwrites the oldest entry,
// and a pop when empty is ignored.
module bp_ras
  import bp_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push_i,
  input  logic                             pop_i,
  input  logic [XLEN-1:0]                  push_addr_i,
  output logic [XLEN-1:0]                  top_o,
  output logic                             empty_o,
  output logic                             full_o,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_inc, ptr_dec;

  // ptr_q names the next slot to write; the top sits one slot behind it.
  assign ptr_inc = (ptr_q == LAST_PTR) ? '0 : ptr_q + 1'b1;
  assign ptr_dec = (ptr_q == '0) ? LAST_PTR : ptr_q - 1'b1;

  assign top_o   = mem_q[ptr_dec];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign count_o = cnt_q;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_inc;
      if (!full_o) cnt_d = cnt_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      ptr_d = ptr_dec;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[ptr_q] <= push_addr_i;
  end

endmodule

// File: rtl/gshare_ras_predictor.sv
// Next-PC predictor: direct-mapped BTB, gshare direction counters and a return
// address stack, all read combinationally from pre-update state.
module gshare_ras_predictor
  import bp_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int BTB_IDX_W = BTB_IDX_W_DEF,
  parameter int PHT_IDX_W = PHT_IDX_W_DEF,
  parameter int GHR_W     = GHR_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  fetch_pc,
  output logic [XLEN-1:0]  pred_pc,
  output logic             pred_taken,
  output logic [GHR_W-1:0] pred_ghr,
  input  logic             upd_valid,
  input  logic [XLEN-1:0]  upd_pc,
  input  logic [XLEN-1:0]  upd_target,
  input  logic [1:0]       upd_type,
  input  logic             upd_taken,
  input  logic [GHR_W-1:0] upd_ghr
);

  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int PHT_N = 1 << PHT_IDX_W;
  localparam int TAG_W = XLEN - BTB_IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [XLEN-1:0]  INSN_BYTES = XLEN'(4);

  if (GHR_W > PHT_IDX_W) begin : g_bad_ghr_w
    $error("GHR_W must not exceed PHT_IDX_W");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end
  if (RAS_DEPTH < 1) begin : g_bad_ras_depth
    $error("RAS_DEPTH must be at least 1");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  logic [BTB_N-1:0] btb_vld_q;
  logic [TAG_W-1:0] btb_tag_q [BTB_N];
  logic [XLEN-1:0]  btb_tgt_q [BTB_N];
  br_type_t         btb_typ_q [BTB_N];
  logic [CNT_W-1:0] pht_q [PHT_N];
  logic [GHR_W-1:0] ghr_q, ghr_d;

  logic                 upd_en;
  logic                 upd_cond;
  br_type_t             upd_typ;
  logic [BTB_IDX_W-1:0] upd_bidx;
  logic [TAG_W-1:0]     upd_tag;
  logic [PHT_IDX_W-1:0] upd_pidx;

  // Reset wins over a coincident update so nothing resolved that cycle survives.
  assign upd_en   = upd_valid & ~reset;
  assign upd_typ  = br_type_t'(upd_type);
  assign upd_cond = upd_en && (upd_typ == COND);
  assign upd_bidx = upd_pc[BTB_IDX_W+1:2];
  assign upd_tag  = upd_pc[XLEN-1:BTB_IDX_W+2];
  assign upd_pidx = upd_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(upd_ghr);

  always_ff @(posedge clk) begin
    if (reset) begin
      btb_vld_q <= '0;
    end else if (upd_en && upd_taken) begin
      btb_vld_q[upd_bidx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (upd_en && upd_taken) begin
      btb_tag_q[upd_bidx] <= upd_tag;
      btb_tgt_q[upd_bidx] <= upd_target;
      btb_typ_q[upd_bidx] <= upd_typ;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= CNT_MAX;
    end else if (upd_cond) begin
      pht_q[upd_pidx] <= upd_taken ? sat_inc(pht_q[upd_pidx])
                                   : sat_dec(pht_q[upd_pidx]);
    end
  end

  always_comb begin
    ghr_d = ghr_q;
    if (upd_cond) ghr_d = (ghr_q << 1) | GHR_W'(upd_taken);
  end

  always_ff @(posedge clk) begin
    if (reset) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end

  logic [XLEN-1:0]                  ras_top;
  logic                             ras_empty;
  logic                             unused_ras_full;
  logic [$clog2(RAS_DEPTH+1)-1:0]   unused_ras_count;

  bp_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .reset       (reset),
    .push_i      (upd_en && (upd_typ == CALL)),
    .pop_i       (upd_en && (upd_typ == RET)),
    .push_addr_i (upd_pc + INSN_BYTES),
    .top_o       (ras_top),
    .empty_o     (ras_empty),
    .full_o      (unused_ras_full),
    .count_o     (unused_ras_count)
  );

  logic [BTB_IDX_W-1:0] fetch_bidx;
  logic [TAG_W-1:0]     fetch_tag;
  logic [PHT_IDX_W-1:0] fetch_pidx;
  logic                 fetch_hit;

  assign fetch_bidx = fetch_pc[BTB_IDX_W+1:2];
  assign fetch_tag  = fetch_pc[XLEN-1:BTB_IDX_W+2];
  assign fetch_pidx = fetch_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr_q);
  assign fetch_hit  = btb_vld_q[fetch_bidx] && (btb_tag_q[fetch_bidx] == fetch_tag);

  always_comb begin
    pred_pc    = fetch_pc + INSN_BYTES;
    pred_taken = 1'b0;
    if (fetch_hit) begin
      case (btb_typ_q[fetch_bidx])
        COND: begin
          if (pht_q[fetch_pidx][CNT_W-1]) begin
            pred_pc    = btb_tgt_q[fetch_bidx];
            pred_taken = 1'b1;
          end
        end
        JUMP, CALL: begin
          pred_pc    = btb_tgt_q[fetch_bidx];
          pred_taken = 1'b1;
        end
        RET: begin
          pred_pc    = ras_empty ? btb_tgt_q[fetch_bidx] : ras_top;
          pred_taken = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pred_ghr = ghr_q;

endmodule

// File: tb/tb_gshare_ras_predictor.sv
// Bench for gshare_ras_predictor: directed scenarios plus randomized traffic
// checked against a queue/array reference model.
module tb_gshare_ras_predictor;

  localparam int RD     = 4;
  localparam int T_COND = 0;
  localparam int T_JUMP = 1;
  localparam int T_CALL = 2;
  localparam int T_RET  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fetch_pc = 32'h0;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [4:0]  pred_ghr;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = 32'h0;
  logic [31:0] upd_target = 32'h0;
  logic [1:0]  upd_type = 2'd0;
  logic        upd_taken = 1'b0;
  logic [4:0]  upd_ghr = 5'd0;

  always #5 clk = ~clk;

  gshare_ras_predictor dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_pc   (fetch_pc),
    .pred_pc    (pred_pc),
    .pred_taken (pred_taken),
    .pred_ghr   (pred_ghr),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_target (upd_target),
    .upd_type   (upd_type),
    .upd_taken  (upd_taken),
    .upd_ghr    (upd_ghr)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  bit          m_v   [32];
  logic [31:0] m_tag [32];
  logic [31:0] m_tgt [32];
  int          m_typ [32];
  int          m_pht [32];
  logic [4:0]  m_ghr;
  logic [31:0] m_ras [$];

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_v[i]   = 1'b0;
      m_pht[i] = 3;
    end
    m_ghr = 5'd0;
    m_ras.delete();
  endfunction

  function automatic void model_update(input logic [31:0] pc, input logic [31:0] tgt,
                                       input int typ, input logic tkn, input logic [4:0] g);
    int bi;
    int pi;
    bi = int'((pc >> 2) % 32);
    pi = int'(((pc >> 2) % 32) ^ {27'd0, g});
    if (tkn) begin
      m_v[bi]   = 1'b1;
      m_tag[bi] = pc >> 7;
      m_tgt[bi] = tgt;
      m_typ[bi] = typ;
    end
    if (typ == T_COND) begin
      if (tkn) m_pht[pi] = (m_pht[pi] < 3) ? m_pht[pi] + 1 : 3;
      else     m_pht[pi] = (m_pht[pi] > 0) ? m_pht[pi] - 1 : 0;
      m_ghr = 5'(({27'd0, m_ghr} * 2 + {31'd0, tkn}) % 32);
    end
    if (typ == T_CALL) begin
      m_ras.push_back(pc + 32'd4);
      if (m_ras.size() > RD) void'(m_ras.pop_front());
    end
    if (typ == T_RET && m_ras.size() > 0) void'(m_ras.pop_back());
  endfunction

  function automatic void model_predict(input logic [31:0] pc, output logic [31:0] ppc,
                                        output logic ptk);
    int bi;
    int pi;
    bi  = int'((pc >> 2) % 32);
    pi  = int'(((pc >> 2) % 32) ^ {27'd0, m_ghr});
    ppc = pc + 32'd4;
    ptk = 1'b0;
    if (m_v[bi] && m_tag[bi] == (pc >> 7)) begin
      if (m_typ[bi] == T_COND) begin
        if (m_pht[pi] >= 2) begin
          ppc = m_tgt[bi];
          ptk = 1'b1;
        end
      end else if (m_typ[bi] == T_RET) begin
        ppc = (m_ras.size() > 0) ? m_ras[$] : m_tgt[bi];
        ptk = 1'b1;
      end else begin
        ppc = m_tgt[bi];
        ptk = 1'b1;
      end
    end
  endfunction

  task automatic do_reset();
    reset     = 1'b1;
    upd_valid = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input int typ,
                     input logic tkn, input logic [4:0] g);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_target = tgt;
    upd_type   = 2'(typ);
    upd_taken  = tkn;
    upd_ghr    = g;
    @(posedge clk);
    if (!reset) model_update(pc, tgt, typ, tkn, g);
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    fetch_pc = 32'h100;
    #1;
    n_total++;
    if (pred_pc !== 32'h104) $display("FAIL reset_pred_pc got %h exp %h", pred_pc, 32'h104);
    else n_pass++;
    n_total++;
    if (pred_taken !== 1'b0) $display("FAIL reset_pred_taken got %b exp 0", pred_taken);
    else n_pass++;
    n_total++;
    if (pred_ghr !== 5'd0) $display("FAIL reset_pred_ghr got %h exp 00", pred_ghr);
    else n_pass++;
  endtask

  task automatic test_cond_taken();
    upd(32'h100, 32'h200, T_COND, 1'b1, 5'd0);
    fetch_pc = 32'h100;
    #1;
    n_total++;
    if (pred_pc !== 32'h200) $display("FAIL cond_pred_pc got %h exp %h", pred_pc, 32'h200);
    else n_pass++;
    n_total++;
    if (pred_taken !== 1'b1) $display("FAIL cond_pred_taken got %b exp 1", pred_taken);
    else n_pass++;
    n_total++;
    if (pred_ghr !== 5'b00001) $display("FAIL cond_pred_ghr got %b exp 00001", pred_ghr);
    else n_pass++;
    // Same BTB index, different tag: must miss.
    fetch_pc = 32'h180;
    #1;
    n_total++;
    if (pred_pc !== 32'h184) $display("FAIL tag_miss_pred_pc got %h exp %h", pred_pc, 32'h184);
    else n_pass++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) upd(32'h100, 32'h200, T_COND, 1'b0, 5'h10);
    fetch_pc = 32'h100;
    #1;
    n_total++;
    if (pred_pc !== 32'h104) $display("FAIL sat_low_pred_pc got %h exp %h", pred_pc, 32'h104);
    else n_pass++;
    n_total++;
    if (pred_taken !== 1'b0) $display("FAIL sat_low_pred_taken got %b exp 0", pred_taken);
    else n_pass++;
    upd(32'h100, 32'h200, T_COND, 1'b0, 5'h10);
    // Rebuild GHR = 10000 using another PC so the saturated counter is read again.
    upd(32'h104, 32'h208, T_COND, 1'b1, 5'd0);
    for (int i = 0; i < 4; i++) upd(32'h104, 32'h208, T_COND, 1'b0, 5'd0);
    fetch_pc = 32'h100;
    #1;
    n_total++;
    if (pred_pc !== 32'h104) $display("FAIL sat_hold_pred_pc got %h exp %h", pred_pc, 32'h104);
    else n_pass++;
    n_total++;
    if (pred_ghr !== 5'b10000) $display("FAIL sat_ghr got %b exp 10000", pred_ghr);
    else n_pass++;
    fetch_pc = 32'h104;
    #1;
    n_total++;
    if (pred_pc !== 32'h208) $display("FAIL other_idx_pred_pc got %h exp %h", pred_pc, 32'h208);
    else n_pass++;
  endtask

  task automatic test_call_ret();
    do_reset();
    upd(32'h40, 32'h300, T_CALL, 1'b1, 5'd0);
    fetch_pc = 32'h40;
    #1;
    n_total++;
    if (pred_pc !== 32'h300 || pred_taken !== 1'b1)
      $display("FAIL call_hit got %h/%b exp %h/1", pred_pc, pred_taken, 32'h300);
    else n_pass++;
    upd(32'h310, 32'h44, T_RET, 1'b1, 5'd0);
    fetch_pc = 32'h310;
    #1;
    n_total++;
    if (pred_pc !== 32'h44) $display("FAIL ret_empty_fallback got %h exp %h", pred_pc, 32'h44);
    else n_pass++;
    upd(32'h80, 32'h300, T_CALL, 1'b1, 5'd0);
    fetch_pc = 32'h310;
    #1;
    n_total++;
    if (pred_pc !== 32'h84 || pred_taken !== 1'b1)
      $display("FAIL ret_ras_top got %h/%b exp %h/1", pred_pc, pred_taken, 32'h84);
    else n_pass++;
    upd(32'h310, 32'h44, T_RET, 1'b1, 5'd0);
    fetch_pc = 32'h310;
    #1;
    n_total++;
    if (pred_pc !== 32'h44) $display("FAIL ret_after_pop got %h exp %h", pred_pc, 32'h44);
    else n_pass++;
    n_total++;
    if (pred_ghr !== 5'd0) $display("FAIL noncond_ghr got %b exp 00000", pred_ghr);
    else n_pass++;
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp_tops [4];
    exp_tops = '{32'h44, 32'h34, 32'h24, 32'h14};
    do_reset();
    upd(32'h504, 32'hABC, T_RET, 1'b1, 5'd0);
    for (int i = 0; i < 5; i++) upd(32'(i * 16), 32'h300, T_CALL, 1'b1, 5'd0);
    for (int i = 0; i < 4; i++) begin
      fetch_pc = 32'h504;
      #1;
      n_total++;
      if (pred_pc !== exp_tops[i]) $display("FAIL ras_top_%0d got %h exp %h", i, pred_pc, exp_tops[i]);
      else n_pass++;
      upd(32'h504, 32'hABC, T_RET, 1'b1, 5'd0);
    end
    fetch_pc = 32'h504;
    #1;
    n_total++;
    if (pred_pc !== 32'hABC) $display("FAIL ras_drained got %h exp %h", pred_pc, 32'hABC);
    else n_pass++;
    upd(32'h504, 32'hABC, T_RET, 1'b1, 5'd0);
    fetch_pc = 32'h504;
    #1;
    n_total++;
    if (pred_pc !== 32'hABC) $display("FAIL ras_pop_empty got %h exp %h", pred_pc, 32'hABC);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    upd(32'h100, 32'h200, T_COND, 1'b0, 5'd0);
    upd(32'h40, 32'h300, T_CALL, 1'b1, 5'd0);
    reset      = 1'b1;
    upd_valid  = 1'b1;
    upd_pc     = 32'h100;
    upd_target = 32'h200;
    upd_type   = 2'(T_COND);
    upd_taken  = 1'b1;
    upd_ghr    = 5'd0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset     = 1'b0;
    upd_valid = 1'b0;
    fetch_pc  = 32'h100;
    #1;
    n_total++;
    if (pred_pc !== 32'h104 || pred_taken !== 1'b0)
      $display("FAIL rst_mid_btb got %h/%b exp %h/0", pred_pc, pred_taken, 32'h104);
    else n_pass++;
    n_total++;
    if (pred_ghr !== 5'd0) $display("FAIL rst_mid_ghr got %b exp 00000", pred_ghr);
    else n_pass++;
    fetch_pc = 32'h40;
    #1;
    n_total++;
    if (pred_pc !== 32'h44) $display("FAIL rst_mid_call_cleared got %h exp %h", pred_pc, 32'h44);
    else n_pass++;
    upd(32'h504, 32'hABC, T_RET, 1'b1, 5'd0);
    fetch_pc = 32'h504;
    #1;
    n_total++;
    if (pred_pc !== 32'hABC) $display("FAIL rst_mid_ras_empty got %h exp %h", pred_pc, 32'hABC);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] pool [8];
    logic [31:0] ppc;
    logic        ptk;
    pool = '{32'h100, 32'h104, 32'h180, 32'h8000_0100, 32'h200, 32'h304, 32'hFFFF_FFFC, 32'h40};
    do_reset();
    for (int it = 0; it < 400; it++) begin
      int          typ;
      logic        uv;
      logic        tkn;
      logic [31:0] tgt;
      logic [4:0]  g;
      typ = int'($urandom_range(0, 3));
      uv  = ($urandom_range(0, 9) < 6);
      tkn = (typ == T_COND) ? 1'($urandom_range(0, 1)) : 1'b1;
      tgt = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 7)] : ($urandom & 32'hFFFF_FFFC);
      g   = ($urandom_range(0, 2) != 0) ? m_ghr : 5'($urandom);
      fetch_pc   = pool[$urandom_range(0, 7)];
      upd_valid  = uv;
      upd_pc     = pool[$urandom_range(0, 7)];
      upd_target = tgt;
      upd_type   = 2'(typ);
      upd_taken  = tkn;
      upd_ghr    = g;
      #1;
      model_predict(fetch_pc, ppc, ptk);
      n_total++;
      if (pred_pc !== ppc) $display("FAIL rnd_pred_pc it=%0d pc=%h got %h exp %h", it, fetch_pc, pred_pc, ppc);
      else n_pass++;
      n_total++;
      if (pred_taken !== ptk) $display("FAIL rnd_pred_taken it=%0d got %b exp %b", it, pred_taken, ptk);
      else n_pass++;
      n_total++;
      if (pred_ghr !== m_ghr) $display("FAIL rnd_pred_ghr it=%0d got %b exp %b", it, pred_ghr, m_ghr);
      else n_pass++;
      @(posedge clk);
      if (uv) model_update(upd_pc, tgt, typ, tkn, g);
      @(negedge clk);
    end
    upd_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_cond_taken();
    test_saturation();
    test_call_ret();
    test_ras_overflow();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
